// File: rtl/dtw_pkg.sv
// Shared constants for the DTW processing element: traceback path codes and operand source selects.
package dtw_pkg;

    localparam logic [1:0] PATH_DIAG   = 2'b11;
    localparam logic [1:0] PATH_UP     = 2'b10;
    localparam logic [1:0] PATH_LEFT   = 2'b01;
    localparam logic [1:0] PATH_ORIGIN = 2'b00;

    localparam logic [1:0] SRC_HOLD   = 2'd0;
    localparam logic [1:0] SRC_PREV   = 2'd1;
    localparam logic [1:0] SRC_GLOBAL = 2'd2;
    localparam logic [1:0] SRC_CLEAR  = 2'd3;

    // Clamp an extended sum back to the cost width, flagging overflow in the MSB of the result.
    function automatic logic [16:0] sat_flag_clamp(input logic [16:0] sum, input int dw);
        logic [16:0] res;
        res = sum;
        if (sum[dw]) begin
            res = '0;
            res[dw] = 1'b1;
            for (int b = 0; b < dw; b++) begin
                res[b] = 1'b1;
            end
        end else begin
            res = sum;
        end
        return res;
    endfunction

endpackage

// File: rtl/dtw_dist_unit.sv
// Combinational local distance between two packed feature vectors: L1 (sum of |d|) or Linf (max |d|).
module dtw_dist_unit
    import dtw_pkg::*;
#(
    parameter int NDIM   = 3,
    parameter int FW     = 10,
    parameter int DIST_W = 13
) (
    input  logic [NDIM*FW-1:0] t_i,
    input  logic [NDIM*FW-1:0] r_i,
    input  logic               metric_i,
    output logic [DIST_W-1:0]  dist_o
);

    logic signed [FW:0] ta_s;
    logic signed [FW:0] rb_s;
    logic signed [FW:0] df_s;
    logic        [FW:0] ad_s;
    logic        [FW:0] mx_s;
    logic [DIST_W-1:0]  sum_s;

    // Per-element absolute difference on FW+1 bits so the full signed range never overflows.
    always_comb begin
        ta_s  = '0;
        rb_s  = '0;
        df_s  = '0;
        ad_s  = '0;
        mx_s  = '0;
        sum_s = '0;
        for (int k = 0; k < NDIM; k++) begin
            ta_s  = signed'({t_i[k*FW+FW-1], t_i[k*FW+:FW]});
            rb_s  = signed'({r_i[k*FW+FW-1], r_i[k*FW+:FW]});
            df_s  = ta_s - rb_s;
            ad_s  = df_s[FW] ? (FW+1)'(-df_s) : (FW+1)'(df_s);
            sum_s = sum_s + DIST_W'(ad_s);
            if (ad_s > mx_s) begin
                mx_s = ad_s;
            end else begin
                mx_s = mx_s;
            end
        end
        if (metric_i) begin
            dist_o = DIST_W'(mx_s);
        end else begin
            dist_o = sum_s;
        end
    end

endmodule

// File: rtl/dtw_pe_pipe.sv
// Pipelined DTW processing element: operand registers, neighbour min-select, and a two-stage
// valid/ready pipe ending in a saturating cost adder.
module dtw_pe_pipe
    import dtw_pkg::*;
#(
    parameter int NDIM = 3,
    parameter int FW   = 10,
    parameter int DW   = 16,
    parameter int IW   = 5
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                ena,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          i_tsrc,
    input  logic [1:0]          i_rsrc,
    input  logic [NDIM*FW-1:0]  T_prev,
    input  logic [NDIM*FW-1:0]  T_global,
    input  logic [NDIM*FW-1:0]  R_prev,
    input  logic [NDIM*FW-1:0]  R_global,
    input  logic [IW-1:0]       i_tindex_prev,
    input  logic [IW-1:0]       i_tindex_glob,
    input  logic [IW-1:0]       i_rindex_prev,
    input  logic [IW-1:0]       i_rindex_glob,
    input  logic [DW-1:0]       D0,
    input  logic [DW-1:0]       D1,
    input  logic [DW-1:0]       D2,
    input  logic [2:0]          i_mask,
    input  logic                i_metric,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NDIM*FW-1:0]  T,
    output logic [NDIM*FW-1:0]  R,
    output logic [IW-1:0]       o_tindex,
    output logic [IW-1:0]       o_rindex,
    output logic [DW-1:0]       D,
    output logic [1:0]          o_path,
    output logic                o_sat
);

    localparam int VW     = NDIM * FW;
    localparam int DIST_W = FW + 1 + $clog2(NDIM);

    logic [VW-1:0]     t_q, r_q, t_mux_s, r_mux_s, t_d, r_d;
    logic [IW-1:0]     tidx_q, ridx_q, tidx_mux_s, ridx_mux_s, tidx_d, ridx_d;
    logic              accept_s, s2_adv_s;
    logic [DIST_W-1:0] dist_s, s1_dist_q;
    logic [DW-1:0]     pair_min_s, min_s, s1_min_q, d_q;
    logic [1:0]        pair_path_s, path_s, s1_path_q, path_q;
    logic              pair_v_s, s1_v_q, ov_q, sat_q;
    logic [DW:0]       sum_s;

    assign s2_adv_s = ~ov_q | out_ready;
    assign in_ready = ena & (~s1_v_q | s2_adv_s);
    assign accept_s = in_valid & in_ready & ena;

    // Test operand source select.
    always_comb begin
        t_mux_s    = t_q;
        tidx_mux_s = tidx_q;
        case (i_tsrc)
            SRC_HOLD:   begin t_mux_s = t_q;      tidx_mux_s = tidx_q;        end
            SRC_PREV:   begin t_mux_s = T_prev;   tidx_mux_s = i_tindex_prev; end
            SRC_GLOBAL: begin t_mux_s = T_global; tidx_mux_s = i_tindex_glob; end
            default:    begin t_mux_s = '0;       tidx_mux_s = '1;            end
        endcase
    end

    // Reference operand source select; a cleared reference is all ones, unlike the test side.
    always_comb begin
        r_mux_s    = r_q;
        ridx_mux_s = ridx_q;
        case (i_rsrc)
            SRC_HOLD:   begin r_mux_s = r_q;      ridx_mux_s = ridx_q;        end
            SRC_PREV:   begin r_mux_s = R_prev;   ridx_mux_s = i_rindex_prev; end
            SRC_GLOBAL: begin r_mux_s = R_global; ridx_mux_s = i_rindex_glob; end
            default:    begin r_mux_s = '1;       ridx_mux_s = '1;            end
        endcase
    end

    // Operand registers only move on an accepted beat.
    always_comb begin
        if (accept_s) begin
            t_d = t_mux_s;   r_d = r_mux_s;
            tidx_d = tidx_mux_s; ridx_d = ridx_mux_s;
        end else begin
            t_d = t_q;       r_d = r_q;
            tidx_d = tidx_q; ridx_d = ridx_q;
        end
    end

    dtw_dist_unit #(.NDIM(NDIM), .FW(FW), .DIST_W(DIST_W)) u_dist (
        .t_i      (t_mux_s),
        .r_i      (r_mux_s),
        .metric_i (i_metric),
        .dist_o   (dist_s)
    );

    // Min of unmasked neighbours; earlier neighbour wins ties (diag over up over left).
    always_comb begin
        if (!i_mask[0] && (i_mask[1] || D0 <= D1)) begin
            pair_min_s = D0; pair_path_s = PATH_DIAG;   pair_v_s = 1'b1;
        end else if (!i_mask[1]) begin
            pair_min_s = D1; pair_path_s = PATH_UP;     pair_v_s = 1'b1;
        end else begin
            pair_min_s = '0; pair_path_s = PATH_ORIGIN; pair_v_s = 1'b0;
        end
        if (pair_v_s && (i_mask[2] || pair_min_s <= D2)) begin
            min_s = pair_min_s; path_s = pair_path_s;
        end else if (!i_mask[2]) begin
            min_s = D2;         path_s = PATH_LEFT;
        end else begin
            min_s = '0;         path_s = PATH_ORIGIN;
        end
    end

    assign sum_s = {1'b0, s1_min_q} + (DW+1)'(s1_dist_q);

    // Operand and index registers; a low enable clears them like reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            t_q <= '0; r_q <= '0; tidx_q <= '1; ridx_q <= '1;
        end else if (!ena) begin
            t_q <= '0; r_q <= '0; tidx_q <= '1; ridx_q <= '1;
        end else begin
            t_q <= t_d; r_q <= r_d; tidx_q <= tidx_d; ridx_q <= ridx_d;
        end
    end

    // Two-stage pipe; the output stage holds while stalled, and a low enable discards in-flight beats.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_v_q <= 1'b0; s1_dist_q <= '0; s1_min_q <= '0; s1_path_q <= PATH_ORIGIN;
            ov_q   <= 1'b0; d_q <= '0; path_q <= PATH_ORIGIN; sat_q <= 1'b0;
        end else if (!ena) begin
            s1_v_q <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            if (accept_s) begin
                s1_v_q    <= 1'b1;
                s1_dist_q <= dist_s;
                s1_min_q  <= min_s;
                s1_path_q <= path_s;
            end else if (s2_adv_s) begin
                s1_v_q <= 1'b0;
            end else begin
                s1_v_q <= s1_v_q;
            end
            if (s2_adv_s) begin
                ov_q <= s1_v_q;
                if (s1_v_q) begin
                    d_q    <= sum_s[DW] ? {DW{1'b1}} : sum_s[DW-1:0];
                    sat_q  <= sum_s[DW];
                    path_q <= s1_path_q;
                end else begin
                    d_q <= d_q; sat_q <= sat_q; path_q <= path_q;
                end
            end else begin
                ov_q <= ov_q;
            end
        end
    end

    assign T         = t_q;
    assign R         = r_q;
    assign o_tindex  = tidx_q;
    assign o_rindex  = ridx_q;
    assign out_valid = ov_q;
    assign D         = d_q;
    assign o_path    = path_q;
    assign o_sat     = sat_q;

endmodule

// File: tb/tb_dtw_pe_pipe.sv
// Directed bench for dtw_pe_pipe: a vector table of single beats plus backpressure and enable-drop sequences.
module tb_dtw_pe_pipe;

    logic        clk = 1'b0;
    logic        nrst, ena, in_valid, in_ready, i_metric, out_valid, out_ready, o_sat;
    logic [1:0]  i_tsrc, i_rsrc, o_path;
    logic [29:0] T_prev, T_global, R_prev, R_global, T, R;
    logic [4:0]  i_tindex_prev, i_tindex_glob, i_rindex_prev, i_rindex_glob, o_tindex, o_rindex;
    logic [15:0] D0, D1, D2, D;
    logic [2:0]  i_mask;

    int checks = 0;
    int errors = 0;

    dtw_pe_pipe dut (
        .clk(clk), .nrst(nrst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
        .i_tsrc(i_tsrc), .i_rsrc(i_rsrc), .T_prev(T_prev), .T_global(T_global),
        .R_prev(R_prev), .R_global(R_global),
        .i_tindex_prev(i_tindex_prev), .i_tindex_glob(i_tindex_glob),
        .i_rindex_prev(i_rindex_prev), .i_rindex_glob(i_rindex_glob),
        .D0(D0), .D1(D1), .D2(D2), .i_mask(i_mask), .i_metric(i_metric),
        .out_valid(out_valid), .out_ready(out_ready), .T(T), .R(R),
        .o_tindex(o_tindex), .o_rindex(o_rindex), .D(D), .o_path(o_path), .o_sat(o_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] t, r;
        logic [15:0] d0, d1, d2;
        logic [2:0]  mask;
        logic        metric;
        logic [15:0] exp_d;
        logic [1:0]  exp_path;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [29:0] pv(input int a, input int b, input int c);
        logic [29:0] v;
        v[9:0]   = a[9:0];
        v[19:10] = b[9:0];
        v[29:20] = c[9:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_n, got_n;
        logic [15:0] got[8];
        logic ir_hist[20];

        // {t, r, d0, d1, d2, mask, metric, exp_d, exp_path, exp_sat}
        vecs[0] = '{pv(1,2,3), pv(4,0,-3), 16'd10, 16'd7, 16'd7, 3'b000, 1'b0, 16'd18, 2'b10, 1'b0};
        vecs[1] = '{pv(1,2,3), pv(4,0,-3), 16'd10, 16'd7, 16'd7, 3'b000, 1'b1, 16'd13, 2'b10, 1'b0};
        vecs[2] = '{pv(1,2,3), pv(4,0,-3), 16'd10, 16'd7, 16'd7, 3'b110, 1'b1, 16'd16, 2'b11, 1'b0};
        vecs[3] = '{pv(1,0,0), pv(4,0,0), 16'd0, 16'd0, 16'd65534, 3'b011, 1'b0, 16'd65535, 2'b01, 1'b1};
        vecs[4] = '{pv(1,2,3), pv(4,0,-3), 16'd1, 16'd1, 16'd1, 3'b111, 1'b0, 16'd11, 2'b00, 1'b0};
        vecs[5] = '{pv(1,2,3), pv(4,0,-3), 16'd5, 16'd5, 16'd5, 3'b000, 1'b0, 16'd16, 2'b11, 1'b0};
        vecs[6] = '{pv(511,-512,0), pv(-512,511,0), 16'd0, 16'd100, 16'd0, 3'b101, 1'b0, 16'd2146, 2'b10, 1'b0};
        vecs[7] = '{pv(1,2,3), pv(4,0,-3), 16'd9, 16'd4, 16'd4, 3'b000, 1'b1, 16'd10, 2'b10, 1'b0};
        vecs[8] = '{pv(1,0,0), pv(4,0,0), 16'd0, 16'd0, 16'd65532, 3'b011, 1'b0, 16'd65535, 2'b01, 1'b0};

        nrst = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1; i_metric = 1'b0;
        i_tsrc = 2'd0; i_rsrc = 2'd0; T_prev = '0; T_global = '0; R_prev = '0; R_global = '0;
        i_tindex_prev = '0; i_tindex_glob = '0; i_rindex_prev = '0; i_rindex_glob = '0;
        D0 = '0; D1 = '0; D2 = '0; i_mask = '0;
        #12 nrst = 1'b1;
        #1;
        chk("reset_D", D, 0);
        chk("reset_path", o_path, 0);
        chk("reset_tindex", o_tindex, 31);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_T", T, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = 1'b1; i_tsrc = 2'd1; i_rsrc = 2'd1;
            T_prev = vecs[i].t; R_prev = vecs[i].r;
            D0 = vecs[i].d0; D1 = vecs[i].d1; D2 = vecs[i].d2;
            i_mask = vecs[i].mask; i_metric = vecs[i].metric;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("vec%0d_T", i), T, vecs[i].t);
            chk($sformatf("vec%0d_R", i), R, vecs[i].r);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_D", i), D, vecs[i].exp_d);
            chk($sformatf("vec%0d_path", i), o_path, vecs[i].exp_path);
            chk($sformatf("vec%0d_sat", i), o_sat, vecs[i].exp_sat);
        end

        // Operand source selects: global / clear, then hold / prev.
        @(negedge clk);
        in_valid = 1'b1; i_tsrc = 2'd2; i_rsrc = 2'd3;
        T_global = pv(5,6,7); i_tindex_glob = 5'd7;
        @(posedge clk); #1;
        chk("src_glob_T", T, pv(5,6,7));
        chk("src_glob_tindex", o_tindex, 7);
        chk("src_clear_R", R, 30'h3FFFFFFF);
        chk("src_clear_rindex", o_rindex, 31);
        @(negedge clk);
        i_tsrc = 2'd0; i_rsrc = 2'd1; T_global = pv(8,8,8);
        R_prev = pv(9,9,9); i_rindex_prev = 5'd3;
        @(posedge clk); #1;
        chk("src_hold_T", T, pv(5,6,7));
        chk("src_hold_tindex", o_tindex, 7);
        chk("src_prev_rindex", o_rindex, 3);
        @(negedge clk);
        in_valid = 1'b0; i_tsrc = 2'd2; i_rsrc = 2'd2;
        @(posedge clk); #1;
        chk("no_accept_hold_T", T, pv(5,6,7));
        repeat (3) @(posedge clk);

        // Backpressure: 4 back-to-back beats with out_ready low for the first 3 cycles.
        acc_n = 0; got_n = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 3);
            if (acc_n < 4) begin
                in_valid = 1'b1; i_tsrc = 2'd1; i_rsrc = 2'd1;
                T_prev = '0; R_prev = '0; i_mask = 3'b011; i_metric = 1'b0;
                D2 = 16'(100 + acc_n);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            ir_hist[cyc] = in_ready;
            if (in_valid && in_ready) acc_n++;
            if (out_valid && out_ready) begin
                if (got_n < 8) got[got_n] = D;
                got_n++;
            end
        end
        chk("bp_in_ready_c0", ir_hist[0], 1);
        chk("bp_in_ready_c1", ir_hist[1], 1);
        chk("bp_in_ready_c2", ir_hist[2], 0);
        chk("bp_delivered_count", got_n, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_order%0d", k), got[k], 100 + k);
        end

        // Enable drop with two beats in flight.
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; i_tsrc = 2'd1; i_rsrc = 2'd1;
        T_prev = pv(1,2,3); R_prev = pv(4,0,-3); i_rindex_prev = 5'd2;
        i_mask = 3'b011; D2 = 16'd200;
        @(negedge clk);
        D2 = 16'd201;
        @(negedge clk);
        in_valid = 1'b0; ena = 1'b0;
        #1;
        chk("ena_low_in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("ena_drop_out_valid", out_valid, 0);
        chk("ena_drop_T", T, 0);
        chk("ena_drop_rindex", o_rindex, 31);
        @(negedge clk);
        ena = 1'b1;
        @(posedge clk); #1;
        chk("ena_restore_no_stale", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
